mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of register-file writeback.
- Passes ALU results through one register stage.
- Performs load/store instructions as a master on the shared system bus (req/ack arbitration, rd/wr/ready transfer).
- Byte stores use an atomic read-modify-write, because block RAM has no byte enables.

Parameters:
- BUS_TIMEOUT, 0, if nonzero, abandon a transfer after this many cycles without bus_ready and assert outbubble. 0 = wait forever.

Ports:
- clk  in  1  system clock
- Nrst  in  1  reset; asynchronous, active-low
- stall  in  1  downstream stall; hold outputs
- flush  in  1  kill the in-flight or incoming instruction
- inbubble  in  1  execute output is a bubble
- inpc  in  32  PC of the incoming instruction
- in_write_reg  in  1  ALU result is to be written
- in_write_num  in  4  ALU destination register
- in_write_data  in  32  ALU result
- mem_valid  in  1  instruction is a load/store
- mem_store  in  1  1 = store, 0 = load
- mem_byte  in  1  byte access (else word)
- mem_addr  in  32  effective address
- mem_wdata  in  32  store data (byte in [7:0])
- mem_dest  in  4  load destination register
- outstall  out  1  execute must hold its outputs
- outbubble  out  1  output is a bubble
- outpc  out  32  PC of the output instruction
- write_reg  out  1  regfile write enable
- write_num  out  4  regfile write register
- write_data  out  32  regfile write data
- bus_req  out  1  arbiter request
- bus_ack  in  1  arbiter grant
- bus_addr  out  32  word address, {mem_addr[31:2],2'b00}
- bus_rdata  in  32  read data
- bus_wdata  out  32  write data
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_ready  in  1  transfer complete
- outfault  out  1  alignment fault (MEM_STAGE_ALIGN_TRAP_EN only; otherwise tied 0)

Behaviour:
- Reset (async, Nrst=0):
  - State goes to IDLE; outbubble=1.
  - All other outputs go to 0, including every bus output.
  - Reset mid-transfer drops bus_req/bus_rd/bus_wr immediately.
- Non-memory path (inbubble=0, mem_valid=0, stall=0): outputs load on the next edge. Latency 1, outstall=0.
- Bubble or flush in IDLE: next edge loads outbubble=1 and write_reg=0.
- Memory op accepted in IDLE when inbubble=0, mem_valid=1, stall=0, flush=0:
  - outstall=1 combinationally in the acceptance cycle.
  - Operands latch; next state is ARB.
  - outstall stays 1 until the completion cycle.
- FSM states: IDLE, ARB, RD, WR, HOLD.
  - ARB: bus_req=1; go to RD on bus_ack. Exception: word store goes to WR.
  - RD: bus_req=1, bus_rd=1. On bus_ready, capture bus_rdata.
    - Load: RD is the completion cycle.
    - Byte store: go to WR with merged word, i.e. lane addr[1:0] replaced by wdata[7:0].
  - WR: bus_req=1, bus_wr=1, bus_wdata valid. On bus_ready, WR is the completion cycle.
  - bus_req stays high continuously across ARB→RD→WR, so the RMW sequence is atomic.
- Completion cycle:
  - outstall=0; next state is IDLE.
  - Output register loads on the edge: load → write_reg=1, write_num=mem_dest, write_data=result; store → write_reg=0.
  - If stall=1 at completion: go to HOLD instead. In HOLD, outstall=1, bus is idle, result is buffered. When stall drops, outputs load and state returns to IDLE.
- Load byte: little-endian; lane = addr[1:0]; zero-extended to 32 bits.
- Flush while busy:
  - In ARB before bus_ack: drop bus_req, go to IDLE, outbubble=1.
  - After bus_ack: the transfer (including a store) completes, then outbubble=1 and write_reg=0.
- BUS_TIMEOUT: counter runs in RD/WR and resets on each state entry. On expiry, drop the bus, go to IDLE, outbubble=1.
- stall while IDLE with no op: outputs hold, outstall=stall.

Optional Feature:
- Macro: MEM_STAGE_ALIGN_TRAP_EN.
- With the macro: a word access with mem_addr[1:0]!=0 makes no bus access. outfault=1 for exactly one cycle, together with outbubble=1 and write_reg=0. Latency is 1 and the stage stays in IDLE.
- Without the macro: addr[1:0] is ignored for word accesses, and outfault is constant 0.

Test Plan:
- ALU pass-through: in_write_reg=1, num=3, data=0x12345678 → next cycle write_reg=1, write_num=3, write_data=0x12345678, outstall=0 throughout.
- Word load @0x100, bus_ack after 2 cycles, bus_ready 1 cycle later with 0xDEADBEEF, mem_dest=5 → bus_addr=0x100; bus_rd high only in RD; write_num=5, write_data=0xDEADBEEF; outstall high from acceptance until completion.
- Byte load @0x103, rdata 0xAABBCCDD → write_data=0x000000AA.
- Byte store @0x101, wdata 0xEE, memory word 0x11223344 → bus_rd then bus_wr, bus_wdata=0x1122EE44; bus_req never drops between them; write_reg=0.
- Flush in ARB → bus_req drops next cycle, no bus_rd, outbubble=1. Nrst low during WR → bus_wr=0 and bus_req=0 immediately, outbubble=1.
- Word load @0x102: with MEM_STAGE_ALIGN_TRAP_EN → outfault=1 for 1 cycle, bus_req stays 0. Without it → bus_addr=0x100 and the load completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU results pass through one register, and loads/stores run as a
// shared-bus master. Byte stores use an atomic read-modify-write. Optional: MEM_STAGE_ALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        stall,
    input  logic        flush,
    input  logic        inbubble,
    input  logic [31:0] inpc,
    input  logic        in_write_reg,
    input  logic [3:0]  in_write_num,
    input  logic [31:0] in_write_data,
    input  logic        mem_valid,
    input  logic        mem_store,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_dest,
    output logic        outstall,
    output logic        outbubble,
    output logic [31:0] outpc,
    output logic        write_reg,
    output logic [3:0]  write_num,
    output logic [31:0] write_data,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_ready,
    output logic        outfault
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        op_store_q, op_store_d;
    logic        op_byte_q, op_byte_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [3:0]  op_dest_q, op_dest_d;
    logic [31:0] op_pc_q, op_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] res_q, res_d;
    logic [31:0] tmr_q, tmr_d;

    logic        obub_q, obub_d;
    logic [31:0] opc_q, opc_d;
    logic        owr_q, owr_d;
    logic [3:0]  onum_q, onum_d;
    logic [31:0] odata_q, odata_d;

    logic        misalign;
    logic        timed_out;
    logic        fin;
    logic [31:0] fin_data;
    logic        fin_kill;
    logic [7:0]  rd_byte;
    logic [31:0] merged;
    logic [31:0] load_res;

`ifdef MEM_STAGE_ALIGN_TRAP_EN
    logic fault_q;

    assign misalign = !mem_byte && (mem_addr[1:0] != 2'b00);

    // Registered pulse: one cycle per rejected misaligned word access.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_q == ST_IDLE) && !stall && !flush && !inbubble && mem_valid &&
                       misalign;
        end
    end

    assign outfault = fault_q;
`else
    assign misalign = 1'b0;
    assign outfault = 1'b0;
`endif

    assign bus_addr   = {op_addr_q[31:2], 2'b00};
    assign bus_wdata  = wdata_q;
    assign outbubble  = obub_q;
    assign outpc      = opc_q;
    assign write_reg  = owr_q;
    assign write_num  = onum_q;
    assign write_data = odata_q;

    assign timed_out = (BUS_TIMEOUT != 0) && (tmr_q == 32'(BUS_TIMEOUT - 1)) && !bus_ready;

    // Little-endian lane select and byte merge for loads and read-modify-write stores.
    always_comb begin
        rd_byte = bus_rdata[7:0];
        merged  = bus_rdata;
        case (op_addr_q[1:0])
            2'd0: begin
                rd_byte = bus_rdata[7:0];
                merged  = {bus_rdata[31:8], op_wdata_lo()};
            end
            2'd1: begin
                rd_byte = bus_rdata[15:8];
                merged  = {bus_rdata[31:16], op_wdata_lo(), bus_rdata[7:0]};
            end
            2'd2: begin
                rd_byte = bus_rdata[23:16];
                merged  = {bus_rdata[31:24], op_wdata_lo(), bus_rdata[15:0]};
            end
            default: begin
                rd_byte = bus_rdata[31:24];
                merged  = {op_wdata_lo(), bus_rdata[23:0]};
            end
        endcase
        load_res = op_byte_q ? {24'd0, rd_byte} : bus_rdata;
    end

    // Store data for a byte store sits in wdata_q until the merge.
    function automatic logic [7:0] op_wdata_lo();
        return wdata_q[7:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        op_store_d = op_store_q;
        op_byte_d  = op_byte_q;
        op_addr_d  = op_addr_q;
        op_dest_d  = op_dest_q;
        op_pc_d    = op_pc_q;
        kill_d     = kill_q;
        wdata_d    = wdata_q;
        res_d      = res_q;
        tmr_d      = tmr_q;
        obub_d     = obub_q;
        opc_d      = opc_q;
        owr_d      = owr_q;
        onum_d     = onum_q;
        odata_d    = odata_q;
        outstall   = 1'b0;
        bus_req    = 1'b0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        fin        = 1'b0;
        fin_data   = res_q;
        fin_kill   = kill_q | flush;

        case (state_q)
            ST_IDLE: begin
                outstall = stall;
                if (!stall) begin
                    opc_d = inpc;
                    if (flush || inbubble || (mem_valid && misalign)) begin
                        obub_d = 1'b1;
                        owr_d  = 1'b0;
                    end else if (mem_valid) begin
                        outstall   = 1'b1;
                        obub_d     = 1'b1;
                        owr_d      = 1'b0;
                        state_d    = ST_ARB;
                        op_store_d = mem_store;
                        op_byte_d  = mem_byte;
                        op_addr_d  = mem_addr;
                        op_dest_d  = mem_dest;
                        op_pc_d    = inpc;
                        kill_d     = 1'b0;
                        wdata_d    = mem_wdata;
                    end else begin
                        obub_d  = 1'b0;
                        owr_d   = in_write_reg;
                        onum_d  = in_write_num;
                        odata_d = in_write_data;
                    end
                end
            end
            ST_ARB: begin
                bus_req  = 1'b1;
                outstall = 1'b1;
                if (bus_ack) begin
                    kill_d  = fin_kill;
                    tmr_d   = 32'd0;
                    state_d = (op_store_q && !op_byte_q) ? ST_WR : ST_RD;
                end else if (flush) begin
                    state_d  = ST_IDLE;
                    outstall = stall;
                end
            end
            ST_RD: begin
                bus_req  = 1'b1;
                bus_rd   = 1'b1;
                outstall = 1'b1;
                kill_d   = fin_kill;
                tmr_d    = tmr_q + 32'd1;
                if (bus_ready) begin
                    if (op_store_q) begin
                        wdata_d = merged;
                        tmr_d   = 32'd0;
                        state_d = ST_WR;
                    end else begin
                        fin      = 1'b1;
                        fin_data = load_res;
                    end
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    obub_d   = 1'b1;
                    owr_d    = 1'b0;
                    outstall = stall;
                end
            end
            ST_WR: begin
                bus_req  = 1'b1;
                bus_wr   = 1'b1;
                outstall = 1'b1;
                kill_d   = fin_kill;
                tmr_d    = tmr_q + 32'd1;
                if (bus_ready) begin
                    fin      = 1'b1;
                    fin_data = res_q;
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    obub_d   = 1'b1;
                    owr_d    = 1'b0;
                    outstall = stall;
                end
            end
            ST_HOLD: begin
                outstall = 1'b1;
                kill_d   = fin_kill;
                if (!stall) begin
                    state_d = ST_IDLE;
                    obub_d  = fin_kill;
                    owr_d   = !op_store_q && !fin_kill;
                    onum_d  = op_dest_q;
                    odata_d = res_q;
                    opc_d   = op_pc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion: publish now, or park the result in HOLD while downstream stalls.
        if (fin) begin
            outstall = stall;
            if (stall) begin
                state_d = ST_HOLD;
                res_d   = fin_data;
                kill_d  = fin_kill;
            end else begin
                state_d = ST_IDLE;
                obub_d  = fin_kill;
                owr_d   = !op_store_q && !fin_kill;
                onum_d  = op_dest_q;
                odata_d = fin_data;
                opc_d   = op_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state_q    <= ST_IDLE;
            op_store_q <= 1'b0;
            op_byte_q  <= 1'b0;
            op_addr_q  <= 32'd0;
            op_dest_q  <= 4'd0;
            op_pc_q    <= 32'd0;
            kill_q     <= 1'b0;
            wdata_q    <= 32'd0;
            res_q      <= 32'd0;
            tmr_q      <= 32'd0;
            obub_q     <= 1'b1;
            opc_q      <= 32'd0;
            owr_q      <= 1'b0;
            onum_q     <= 4'd0;
            odata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_store_q <= op_store_d;
            op_byte_q  <= op_byte_d;
            op_addr_q  <= op_addr_d;
            op_dest_q  <= op_dest_d;
            op_pc_q    <= op_pc_d;
            kill_q     <= kill_d;
            wdata_q    <= wdata_d;
            res_q      <= res_d;
            tmr_q      <= tmr_d;
            obub_q     <= obub_d;
            opc_q      <= opc_d;
            owr_q      <= owr_d;
            onum_q     <= onum_d;
            odata_q    <= odata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, byte RMW store, flush, stall/HOLD, reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        Nrst;
    logic        stall, flush, inbubble;
    logic [31:0] inpc;
    logic        in_write_reg;
    logic [3:0]  in_write_num;
    logic [31:0] in_write_data;
    logic        mem_valid, mem_store, mem_byte;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_dest;
    logic        outstall, outbubble;
    logic [31:0] outpc;
    logic        write_reg;
    logic [3:0]  write_num;
    logic [31:0] write_data;
    logic        bus_req, bus_ack;
    logic [31:0] bus_addr, bus_rdata, bus_wdata;
    logic        bus_rd, bus_wr, bus_ready;
    logic        outfault;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage dut (
        .clk          (clk),
        .Nrst         (Nrst),
        .stall        (stall),
        .flush        (flush),
        .inbubble     (inbubble),
        .inpc         (inpc),
        .in_write_reg (in_write_reg),
        .in_write_num (in_write_num),
        .in_write_data(in_write_data),
        .mem_valid    (mem_valid),
        .mem_store    (mem_store),
        .mem_byte     (mem_byte),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_dest     (mem_dest),
        .outstall     (outstall),
        .outbubble    (outbubble),
        .outpc        (outpc),
        .write_reg    (write_reg),
        .write_num    (write_num),
        .write_data   (write_data),
        .bus_req      (bus_req),
        .bus_ack      (bus_ack),
        .bus_addr     (bus_addr),
        .bus_rdata    (bus_rdata),
        .bus_wdata    (bus_wdata),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_ready    (bus_ready),
        .outfault     (outfault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        inbubble  = 1'b1;
        mem_valid = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        bus_ack   = 1'b0;
        bus_ready = 1'b0;
    endtask

    task automatic mem_op(input logic st, input logic by, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] dest);
        inbubble  = 1'b0;
        mem_valid = 1'b1;
        mem_store = st;
        mem_byte  = by;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_dest  = dest;
        inpc      = 32'h44;
    endtask

    initial begin
        Nrst = 1'b0;
        stall = 0; flush = 0; inbubble = 1; inpc = 0;
        in_write_reg = 0; in_write_num = 0; in_write_data = 0;
        mem_valid = 0; mem_store = 0; mem_byte = 0; mem_addr = 0; mem_wdata = 0; mem_dest = 0;
        bus_ack = 0; bus_rdata = 0; bus_ready = 0;
        #12;
        check("rst_bubble", outbubble, 1);
        check("rst_wreg", write_reg, 0);
        check("rst_wdata", write_data, 0);
        check("rst_req", bus_req, 0);
        check("rst_stall", outstall, 0);
        check("rst_fault", outfault, 0);
        Nrst = 1'b1;
        tick();

        // ALU pass-through
        inbubble = 0; mem_valid = 0; in_write_reg = 1; in_write_num = 3;
        in_write_data = 32'h12345678; inpc = 32'h40;
        #1 check("alu_stall", outstall, 0);
        tick();
        check("alu_wreg", write_reg, 1);
        check("alu_num", write_num, 3);
        check("alu_data", write_data, 32'h12345678);
        check("alu_bub", outbubble, 0);
        check("alu_pc", outpc, 32'h40);

        // stall in IDLE holds outputs
        stall = 1; in_write_data = 32'h9999;
        #1 check("idle_stall", outstall, 1);
        tick();
        check("idle_hold", write_data, 32'h12345678);
        stall = 0; in_write_reg = 0;

        // word load @0x100
        mem_op(0, 0, 32'h100, 0, 5);
        #1 check("ld_acc_stall", outstall, 1);
        check("ld_acc_req", bus_req, 0);
        tick();
        idle_in();
        #1 check("ld_arb_req", bus_req, 1);
        check("ld_arb_rd", bus_rd, 0);
        check("ld_addr", bus_addr, 32'h100);
        check("ld_arb_stall", outstall, 1);
        tick();
        bus_ack = 1;
        tick();
        bus_ack = 0;
        #1 check("ld_rd", bus_rd, 1);
        tick();
        bus_ready = 1; bus_rdata = 32'hDEADBEEF;
        #1 check("ld_done_stall", outstall, 0);
        tick();
        bus_ready = 0;
        check("ld_wreg", write_reg, 1);
        check("ld_num", write_num, 5);
        check("ld_data", write_data, 32'hDEADBEEF);
        check("ld_pc", outpc, 32'h44);
        check("ld_rd_off", bus_rd, 0);
        check("ld_req_off", bus_req, 0);

        // byte load @0x103
        mem_op(0, 1, 32'h103, 0, 2);
        tick();
        idle_in(); bus_ack = 1;
        tick();
        bus_ack = 0; bus_ready = 1; bus_rdata = 32'hAABBCCDD;
        tick();
        bus_ready = 0;
        check("lb_data", write_data, 32'h000000AA);
        check("lb_num", write_num, 2);

        // byte store @0x101 (RMW)
        mem_op(1, 1, 32'h101, 32'h000000EE, 0);
        tick();
        idle_in(); bus_ack = 1;
        tick();
        bus_ack = 0; bus_ready = 1; bus_rdata = 32'h11223344;
        #1 check("sb_rd", bus_rd, 1);
        check("sb_rd_wr", bus_wr, 0);
        check("sb_rd_stall", outstall, 1);
        tick();
        #1 check("sb_req", bus_req, 1);
        check("sb_wr", bus_wr, 1);
        check("sb_wr_rd", bus_rd, 0);
        check("sb_wdata", bus_wdata, 32'h1122EE44);
        check("sb_done_stall", outstall, 0);
        tick();
        bus_ready = 0;
        check("sb_wreg", write_reg, 0);
        check("sb_bub", outbubble, 0);
        check("sb_req_off", bus_req, 0);

        // flush in ARB
        mem_op(0, 0, 32'h80, 0, 1);
        tick();
        idle_in(); flush = 1;
        tick();
        flush = 0;
        #1 check("fl_req", bus_req, 0);
        check("fl_rd", bus_rd, 0);
        check("fl_bub", outbubble, 1);
        check("fl_stall", outstall, 0);

        // stall at completion -> HOLD
        mem_op(0, 0, 32'h10, 0, 7);
        tick();
        idle_in(); bus_ack = 1;
        tick();
        bus_ack = 0; bus_ready = 1; bus_rdata = 32'h0BADF00D; stall = 1;
        #1 check("hold_enter_stall", outstall, 1);
        tick();
        bus_ready = 0;
        #1 check("hold_req", bus_req, 0);
        check("hold_stall", outstall, 1);
        check("hold_wreg", write_reg, 0);
        tick();
        stall = 0;
        tick();
        check("hold_out_wreg", write_reg, 1);
        check("hold_out_num", write_num, 7);
        check("hold_out_data", write_data, 32'h0BADF00D);

        // flush after ack: transfer completes, result dropped
        mem_op(0, 0, 32'h20, 0, 9);
        tick();
        idle_in(); bus_ack = 1;
        tick();
        bus_ack = 0; flush = 1;
        tick();
        flush = 0; bus_ready = 1; bus_rdata = 32'h1;
        #1 check("fa_stall", outstall, 0);
        tick();
        bus_ready = 0;
        check("fa_bub", outbubble, 1);
        check("fa_wreg", write_reg, 0);

        // reset during WR
        mem_op(1, 0, 32'h200, 32'hCAFEF00D, 0);
        tick();
        idle_in(); bus_ack = 1;
        tick();
        bus_ack = 0;
        #1 check("rw_wr", bus_wr, 1);
        check("rw_wdata", bus_wdata, 32'hCAFEF00D);
        Nrst = 0;
        #1 check("rw_wr_off", bus_wr, 0);
        check("rw_req_off", bus_req, 0);
        check("rw_bub", outbubble, 1);
        tick();
        Nrst = 1;
        tick();

        // word load @0x102
        mem_op(0, 0, 32'h102, 0, 4);
`ifdef MEM_STAGE_ALIGN_TRAP_EN
        #1 check("mis_stall", outstall, 0);
        tick();
        idle_in();
        check("mis_fault", outfault, 1);
        check("mis_bub", outbubble, 1);
        check("mis_wreg", write_reg, 0);
        check("mis_req", bus_req, 0);
        tick();
        check("mis_fault_off", outfault, 0);
        check("mis_req2", bus_req, 0);
`else
        #1 check("mis_stall", outstall, 1);
        tick();
        idle_in();
        #1 check("mis_addr", bus_addr, 32'h100);
        bus_ack = 1;
        tick();
        bus_ack = 0; bus_ready = 1; bus_rdata = 32'h55667788;
        tick();
        bus_ready = 0;
        check("mis_wreg", write_reg, 1);
        check("mis_data", write_data, 32'h55667788);
        check("mis_fault", outfault, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
